// File: rtl/digital_pll_lock_detect.sv
// ----------------------------------------------------------------------------
// digital_pll_lock_detect
//
// Lock detector that sits behind the digital PLL trim controller. It counts
// i_clock cycles between rising edges of the reference i_osc and compares
// each measured period with the target i_div. A hysteretic FSM declares lock
// after LOCK_COUNT consecutive good periods. It drops lock after UNLOCK_COUNT
// consecutive bad periods, or at once when the reference stops toggling.
//
// Parameters:
//   LOCK_COUNT    consecutive good periods needed to declare lock (1..31)
//   UNLOCK_COUNT  consecutive bad periods needed to drop lock     (1..31)
//   TOL           allowed |period - div| for a good period         (0..7)
//
// Ports:
//   i_clock       PLL output clock, the only clock of this block
//   i_resetb      asynchronous active-low reset
//   i_osc         reference clock, asynchronous to i_clock
//   i_div[4:0]    target i_clock cycles per i_osc period (0 = never good)
//   i_trim[25:0]  thermometer trim code from the PLL controller
//   i_enable      detector enable; low holds the FSM in SEARCH
//   i_clr_lost    single-cycle pulse that clears o_lost_lock
//   o_locked      lock indication (LOCKED or SLIP, one cycle behind state)
//   o_lost_lock   sticky flag: lock was dropped since the last clear
//   o_period[5:0] last evaluated period in i_clock cycles, saturating at 63
//   o_trim_level  registered popcount of i_trim (0..26)
//   o_at_rail     trim level at 0 or 26 while locked
//   o_state[1:0]  SEARCH=0, VERIFY=1, LOCKED=2, SLIP=3
// ----------------------------------------------------------------------------
module digital_pll_lock_detect #(
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4,
    parameter int TOL          = 1
) (
    input  logic        i_clock,
    input  logic        i_resetb,
    input  logic        i_osc,
    input  logic [4:0]  i_div,
    input  logic [25:0] i_trim,
    input  logic        i_enable,
    input  logic        i_clr_lost,
    output logic        o_locked,
    output logic        o_lost_lock,
    output logic [5:0]  o_period,
    output logic [4:0]  o_trim_level,
    output logic        o_at_rail,
    output logic [1:0]  o_state
);

    localparam logic [5:0] CNT_MAX     = 6'd63;
    localparam logic [5:0] CNT_WD      = 6'd62;
    localparam logic [4:0] LOCK_TGT    = 5'(LOCK_COUNT);
    localparam logic [4:0] UNLOCK_TGT  = 5'(UNLOCK_COUNT);
    localparam logic [6:0] TOL_W       = 7'(TOL);
    localparam logic [4:0] TRIM_FULL   = 5'd26;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_oscbuf;
    logic [5:0]  r_cnt;
    logic        r_meas_valid;
    logic [4:0]  r_good_cnt;
    logic [4:0]  r_bad_cnt;
    logic        r_locked;
    logic        r_lost_lock;
    logic [5:0]  r_period;
    logic [4:0]  r_trim_level;
    logic        r_at_rail;

    logic              w_tick;
    logic              w_watchdog;
    logic signed [6:0] w_diff;
    logic [6:0]        w_abs_diff;
    logic              w_good;
    logic [4:0]        w_popcount;

    // Rising edge of the synchronised reference, seen between flops 1 and 2.
    assign w_tick = r_oscbuf[1] & ~r_oscbuf[2];

    // The counter is about to saturate: the reference has stopped.
    assign w_watchdog = ~w_tick && (r_cnt == CNT_WD);

    // On a tick r_cnt holds the cycles since the previous tick. The 7-bit
    // signed difference covers -31..63 without wrapping.
    assign w_diff     = $signed({1'b0, r_cnt}) - $signed({2'b00, i_div});
    assign w_abs_diff = w_diff[6] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_good     = r_meas_valid && (i_div != 5'd0) && (w_abs_diff <= TOL_W);

    always_comb begin
        w_popcount = 5'd0;
        for (int k = 0; k < 26; k++) begin
            w_popcount = w_popcount + {4'd0, i_trim[k]};
        end
    end

    always_ff @(posedge i_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state      <= SEARCH;
            r_oscbuf     <= 3'd0;
            r_cnt        <= 6'd0;
            r_meas_valid <= 1'b0;
            r_good_cnt   <= 5'd0;
            r_bad_cnt    <= 5'd0;
            r_locked     <= 1'b0;
            r_lost_lock  <= 1'b0;
            r_period     <= 6'd0;
            r_trim_level <= 5'd0;
            r_at_rail    <= 1'b0;
        end else begin
            r_oscbuf     <= {r_oscbuf[1:0], i_osc};
            r_trim_level <= w_popcount;
            r_at_rail    <= r_locked && ((r_trim_level == 5'd0) || (r_trim_level == TRIM_FULL));

            // Period counter runs regardless of enable so that measurement
            // timing does not depend on when the detector is switched on.
            if (w_tick) begin
                r_cnt <= 6'd1;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 6'd1;
            end

            // locked follows the state one cycle later.
            r_locked <= i_enable && ((r_state == LOCKED) || (r_state == SLIP));

            // Clear first; any set below overrides it in the same cycle.
            if (i_clr_lost) begin
                r_lost_lock <= 1'b0;
            end

            if (!i_enable) begin
                r_state      <= SEARCH;
                r_good_cnt   <= 5'd0;
                r_bad_cnt    <= 5'd0;
                r_meas_valid <= 1'b0;
            end else if (w_watchdog) begin
                r_state      <= SEARCH;
                r_good_cnt   <= 5'd0;
                r_bad_cnt    <= 5'd0;
                r_meas_valid <= 1'b0;
                if ((r_state == LOCKED) || (r_state == SLIP)) begin
                    r_lost_lock <= 1'b1;
                end
            end else if (w_tick) begin
                // A tick with no valid previous edge only primes the measurement.
                r_meas_valid <= 1'b1;
                if (r_meas_valid) begin
                    r_period <= r_cnt;
                    case (r_state)
                        SEARCH: begin
                            if (w_good) begin
                                if (LOCK_TGT == 5'd1) begin
                                    r_state    <= LOCKED;
                                    r_good_cnt <= 5'd0;
                                end else begin
                                    r_state    <= VERIFY;
                                    r_good_cnt <= 5'd1;
                                end
                            end
                        end
                        VERIFY: begin
                            if (w_good) begin
                                if ((r_good_cnt + 5'd1) == LOCK_TGT) begin
                                    r_state    <= LOCKED;
                                    r_good_cnt <= 5'd0;
                                end else begin
                                    r_good_cnt <= r_good_cnt + 5'd1;
                                end
                            end else begin
                                r_state    <= SEARCH;
                                r_good_cnt <= 5'd0;
                            end
                        end
                        LOCKED: begin
                            if (!w_good) begin
                                if (UNLOCK_TGT == 5'd1) begin
                                    r_state     <= SEARCH;
                                    r_bad_cnt   <= 5'd0;
                                    r_lost_lock <= 1'b1;
                                end else begin
                                    r_state   <= SLIP;
                                    r_bad_cnt <= 5'd1;
                                end
                            end
                        end
                        SLIP: begin
                            if (w_good) begin
                                r_state   <= LOCKED;
                                r_bad_cnt <= 5'd0;
                            end else if ((r_bad_cnt + 5'd1) == UNLOCK_TGT) begin
                                r_state     <= SEARCH;
                                r_bad_cnt   <= 5'd0;
                                r_lost_lock <= 1'b1;
                            end else begin
                                r_bad_cnt <= r_bad_cnt + 5'd1;
                            end
                        end
                        default: begin
                            r_state <= SEARCH;
                        end
                    endcase
                end
            end
        end
    end

    assign o_locked     = r_locked;
    assign o_lost_lock  = r_lost_lock;
    assign o_period     = r_period;
    assign o_trim_level = r_trim_level;
    assign o_at_rail    = r_at_rail;
    assign o_state      = r_state;

endmodule

// File: doc/digital_pll_lock_detect.md
Name: digital_pll_lock_detect

Overview:
Lock detector downstream of the digital PLL trim controller. Consumes the same reference `osc` and target `div` as the controller, plus its 26-bit thermometer `trim`. It measures `clock` cycles per reference period and runs a hysteretic lock state machine. It reports `locked`, a sticky lost-lock flag, the last measured period and the trim level, for the clock-mux enable and housekeeping status registers.

Parameters:
LOCK_COUNT, 16, consecutive good periods required to declare lock (1..31)
UNLOCK_COUNT, 4, consecutive bad periods required to drop lock (1..31)
TOL, 1, allowed |period - div| for a period to count as good (0..7)

Ports:
clock  input  1  PLL output clock (ring oscillator), sole clock
resetb  input  1  asynchronous active-low reset
osc  input  1  reference clock, asynchronous to clock
div  input  5  target clock cycles per osc period
trim  input  26  thermometer trim code from the PLL controller
enable  input  1  detector enable; 0 holds the FSM in SEARCH
clr_lost  input  1  single-cycle pulse, clears lost_lock
locked  output  1  lock indication
lost_lock  output  1  sticky: lock was dropped since last clear
period  output  6  last measured period in clock cycles, saturating at 63
trim_level  output  5  popcount of trim (0..26), registered
at_rail  output  1  trim_level is 0 or 26 while locked
state  output  2  FSM state: SEARCH=0, VERIFY=1, LOCKED=2, SLIP=3

Behaviour:
- Reset (resetb low, async): all outputs 0.
  - Internal: oscbuf=0, cnt=0, meas_valid=0, good_cnt=0, bad_cnt=0, state=SEARCH.
- Synchroniser and tick:
  - 3-flop oscbuf shift of osc.
  - tick is asserted when oscbuf[2]==0 and oscbuf[1]==1 (rising edge).
- Period counter cnt (6 bits):
  - On tick: cnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at 63.
  - On tick, meas=cnt (ticks P cycles apart give meas=P). period<=meas and meas_valid<=1.
  - The first tick after reset, enable rise or a watchdog event only sets meas_valid. No FSM evaluation and no period update on that tick.
- Good period: meas_valid && div!=0 && |meas - div| <= TOL, computed in 7-bit signed arithmetic. div==0 makes every period bad.
- FSM transitions, evaluated only on ticks with meas_valid==1:
  - SEARCH: good -> VERIFY with good_cnt=1; bad -> stay.
  - VERIFY: good -> good_cnt+1; when good_cnt+1==LOCK_COUNT -> LOCKED and good_cnt=0. Bad -> SEARCH with good_cnt=0.
  - LOCKED: good -> stay; bad -> SLIP with bad_cnt=1.
  - SLIP: good -> LOCKED with bad_cnt=0. Bad -> bad_cnt+1; when bad_cnt+1==UNLOCK_COUNT -> SEARCH, bad_cnt=0, set lost_lock.
  - LOCK_COUNT=1 or UNLOCK_COUNT=1: the first qualifying period transitions directly.
- locked is registered: 1 in the cycle after entering LOCKED, stays 1 through SLIP, and falls in the cycle after entering SEARCH.
- Watchdog: cnt reaching 63 (the transition 62->63) means osc has stopped.
  - Forces SEARCH, clears good_cnt, bad_cnt and meas_valid.
  - If the state was LOCKED or SLIP, sets lost_lock.
- enable=0: state forced to SEARCH, counters cleared, meas_valid=0, locked=0. lost_lock is not set by disable.
- lost_lock:
  - Set by either drop path.
  - Cleared by clr_lost.
  - Set has priority when both occur in the same cycle.
- trim_level: popcount(trim) registered each cycle; 1-cycle latency. No thermometer-validity checking.
- at_rail: registered; equals locked && (trim_level==0 || trim_level==26).
- div change while locked: the next evaluated period is compared against the new div.
- resetb mid-operation: immediate clear. The first post-reset tick is measurement-only.

Test Plan:
1. div=8, osc period exactly 8 clocks, defaults: locked rises after 1 priming tick + 16 good periods (17th tick, +1 cycle); period=8; state=2.
2. Locked at div=8, then 3 periods of 11 followed by a period of 8: state goes 3 then 2, locked stays 1, lost_lock=0. Then 4 consecutive periods of 11: state=0, locked=0, lost_lock=1.
3. VERIFY with good_cnt=10, one period of 10 (|10-8|>1): state returns to 0. A period of 9 (within TOL) instead keeps counting toward lock.
4. Locked, then osc held low: after cnt saturates, state=0, locked=0, lost_lock=1, period holds its last value. Restarting osc needs a priming tick plus 16 good periods to relock.
5. lost_lock=1, then clr_lost pulsed in the same cycle as a new SLIP->SEARCH drop: lost_lock stays 1. A clr_lost alone clears it next cycle.
6. trim=26'h3FFFFFF while locked: trim_level=26, at_rail=1. trim=26'b…0010001001001: trim_level=4, at_rail=0. div=0: lock is never reached.
